// File: rtl/irq_prio_pkg.sv
// Shared constants, types and the fixed-priority helper for the interrupt responder.
package irq_prio_pkg;

  localparam int unsigned CAUSE_W            = 5;
  localparam int unsigned DEFAULT_BASE_CAUSE = 16;
  localparam int unsigned MAX_IRQ            = 32;

  // Line indices of the named request sources.
  localparam int unsigned IRQ_DIO1  = 0;
  localparam int unsigned IRQ_TIMER = 1;

  typedef struct packed {
    logic               valid;
    logic [CAUSE_W-1:0] idx;
  } prio_t;

  // Lowest set bit wins; valid is 0 when the vector is empty.
  function automatic prio_t prio_index(input logic [MAX_IRQ-1:0] vec);
    prio_t res;
    res = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.valid = 1'b1;
        res.idx   = CAUSE_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: multi-flop synchroniser, previous-level flop and rise detect.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_raw,
  output logic irq_sync,
  output logic irq_rise
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("irq_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchroniser and remember the last synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_sync = sync_q[SYNC_STAGES-1];
  assign irq_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_edge_prio.sv
// Interrupt responder: sticky/level pending bits, enable masking and a registered
// fixed-priority request with its mcause value.
module irq_edge_prio
  import irq_prio_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned BASE_CAUSE  = DEFAULT_BASE_CAUSE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_level,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               clr_valid,
  input  logic [NUM_IRQ-1:0] clr_mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic               irq_req,
  output logic [CAUSE_W-1:0] irq_cause
);

  logic [NUM_IRQ-1:0] sync_lvl;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               req_q, req_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [NUM_IRQ-1:0] active;
  logic [MAX_IRQ-1:0] active_ext;
  prio_t              win;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_raw (irq_in[g]),
      .irq_sync(sync_lvl[g]),
      .irq_rise(rise[g])
    );
  end

  // Pending next state: level lines track the synced input; edge lines set on rise,
  // and a rise in the same cycle as a clear wins so no edge is lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_level[i]) begin
        pending_d[i] = sync_lvl[i];
      end else begin
        pending_d[i] = rise[i] | (pending_q[i] & ~(clr_valid & clr_mask[i]));
      end
    end
  end

  // Priority is resolved on the next-state vector so the cause never lags pending.
  always_comb begin
    active                  = pending_d & irq_enable;
    active_ext              = '0;
    active_ext[NUM_IRQ-1:0] = active;
    win                     = prio_index(active_ext);
    req_d                   = win.valid;
    cause_d                 = win.valid ? (CAUSE_W'(BASE_CAUSE) + win.idx) : '0;
  end

  // Pending bits and the request/cause outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      req_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req_d;
      cause_q   <= cause_d;
    end
  end

  assign pending   = pending_q;
  assign irq_req   = req_q;
  assign irq_cause = cause_q;

endmodule

// File: tb/tb_irq_edge_prio.sv
// Bench for irq_edge_prio: directed cycle table, reset sequence, then random
// stimulus against a sample-history reference model.
module tb_irq_edge_prio;
  import irq_prio_pkg::*;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_in, irq_level, irq_enable, clr_mask;
  logic         clr_valid;
  logic [N-1:0] pending;
  logic         irq_req;
  logic [4:0]   irq_cause;

  always #5 clk = ~clk;

  irq_edge_prio #(
    .NUM_IRQ    (N),
    .BASE_CAUSE (16),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .irq_level (irq_level),
    .irq_enable(irq_enable),
    .clr_valid (clr_valid),
    .clr_mask  (clr_mask),
    .pending   (pending),
    .irq_req   (irq_req),
    .irq_cause (irq_cause)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N-1:0] ep, input logic er,
                       input logic [4:0] ec);
    n_cmp++;
    if (pending !== ep || irq_req !== er || irq_cause !== ec) begin
      n_bad++;
      $display("FAIL %s: got pending=%b req=%b cause=%0d, want pending=%b req=%b cause=%0d",
               name, pending, irq_req, irq_cause, ep, er, ec);
    end
  endtask

  // Reference model: the synced level before edge n is the input sampled S edges
  // earlier; hist[j] holds the sample taken j+1 edges ago.
  logic [N-1:0] hist [0:S];
  logic [N-1:0] m_pend;

  task automatic model_reset();
    for (int j = 0; j <= S; j++) hist[j] = '0;
    m_pend = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] lvl_now, lvl_old;
    lvl_now = hist[S-1];
    lvl_old = hist[S];
    for (int i = 0; i < N; i++) begin
      if (irq_level[i])                   m_pend[i] = lvl_now[i];
      else if (lvl_now[i] && !lvl_old[i]) m_pend[i] = 1'b1;
      else if (clr_valid && clr_mask[i])  m_pend[i] = 1'b0;
    end
    for (int j = S; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = irq_in;
  endtask

  function automatic logic [4:0] cause_of(input logic [N-1:0] act);
    for (int i = 0; i < N; i++) if (act[i]) return 5'(16 + i);
    return 5'd0;
  endfunction

  typedef struct packed {
    logic [N-1:0] in;
    logic [N-1:0] lvl;
    logic [N-1:0] en;
    logic         cv;
    logic [N-1:0] cm;
    logic [N-1:0] ep;
    logic         er;
    logic [4:0]   ec;
  } vec_t;

  vec_t tbl [0:27];

  initial begin
    // Timer pulse, cleared after service.
    tbl[0]  = '{4'b0010, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[1]  = '{4'b0010, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[2]  = '{4'b0010, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 5'd17};
    tbl[3]  = '{4'b0010, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 5'd17};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0011, 1'b1, 4'b0010, 4'b0000, 1'b0, 5'd0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    // Simultaneous rise on lines 0 and 1; clears hand over without a bubble.
    tbl[6]  = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[7]  = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[8]  = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0011, 1'b1, 5'd16};
    tbl[9]  = '{4'b0011, 4'b0000, 4'b0011, 1'b1, 4'b0001, 4'b0010, 1'b1, 5'd17};
    tbl[10] = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 5'd17};
    tbl[11] = '{4'b0011, 4'b0000, 4'b0011, 1'b1, 4'b0010, 4'b0000, 1'b0, 5'd0};
    // Line 0 low then high again; its rise meets a clear of the same bit.
    tbl[12] = '{4'b0010, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[13] = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[14] = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[15] = '{4'b0011, 4'b0000, 4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1, 5'd16};
    tbl[16] = '{4'b0011, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 5'd16};
    // Disabled line 2 captures its edge, requests once enabled.
    tbl[17] = '{4'b0111, 4'b0000, 4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b0, 5'd0};
    tbl[18] = '{4'b0111, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[19] = '{4'b0111, 4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0100, 1'b0, 5'd0};
    tbl[20] = '{4'b0111, 4'b0000, 4'b0111, 1'b0, 4'b0000, 4'b0100, 1'b1, 5'd18};
    tbl[21] = '{4'b0111, 4'b0000, 4'b0111, 1'b1, 4'b0100, 4'b0000, 1'b0, 5'd0};
    // Level mode on line 3: follows the synced input, clears ignored.
    tbl[22] = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[23] = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};
    tbl[24] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 5'd19};
    tbl[25] = '{4'b0000, 4'b1000, 4'b1000, 1'b1, 4'b1111, 4'b1000, 1'b1, 5'd19};
    tbl[26] = '{4'b0000, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1, 5'd19};
    tbl[27] = '{4'b0000, 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0};

    rst_n      = 1'b0;
    irq_in     = '0;
    irq_level  = '0;
    irq_enable = '0;
    clr_valid  = 1'b0;
    clr_mask   = '0;
    #12;
    check("reset_state", 4'b0000, 1'b0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 28; r++) begin
      irq_in     = tbl[r].in;
      irq_level  = tbl[r].lvl;
      irq_enable = tbl[r].en;
      clr_valid  = tbl[r].cv;
      clr_mask   = tbl[r].cm;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", r), tbl[r].ep, tbl[r].er, tbl[r].ec);
    end

    // Pend two lines, then assert reset mid-operation.
    irq_in                = '0;
    irq_in[IRQ_DIO1]      = 1'b1;
    irq_in[IRQ_TIMER]     = 1'b1;
    irq_level             = '0;
    irq_enable            = 4'b0011;
    clr_valid             = 1'b0;
    clr_mask              = '0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset", 4'b0011, 1'b1, 5'd16);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 1'b0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Inputs still high: the rise propagates after release.
    @(posedge clk); #1;
    check("post_rst1", 4'b0000, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("post_rst2", 4'b0000, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("post_rst3", 4'b0011, 1'b1, 5'd16);

    // Random phase from a fresh reset.
    rst_n = 1'b0;
    irq_in = '0;
    irq_level = '0;
    irq_enable = '0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ N'($urandom);
      if ($urandom_range(0, 39) == 0) irq_level = N'($urandom);
      if ($urandom_range(0, 9) == 0) irq_enable = N'($urandom);
      clr_valid = ($urandom_range(0, 3) == 0);
      clr_mask  = N'($urandom);
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", c), m_pend, |(m_pend & irq_enable),
            cause_of(m_pend & irq_enable));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
